// File: rtl/adc_cal_pkg.sv
// ---------------------------------------------------------------------------
// adc_cal_pkg
// Shared definitions for the ADC IDELAY tap calibration block:
//   TAP_W   - width of an IDELAY tap value (0..511)
//   LEN_W   - width of a run length (0..512)
//   CNT_W   - width of the settle/sample/strobe cycle counter
//   MAX_TAP - last tap visited by the sweep
//   cal_state_e - calibration FSM states
// ---------------------------------------------------------------------------
package adc_cal_pkg;

    localparam int TAP_W = 9;
    localparam int LEN_W = 10;
    localparam int CNT_W = 16;

    localparam logic [TAP_W-1:0] MAX_TAP = 9'd511;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        SETTLE,
        CHECK,
        SAMPLE,
        NEXT,
        CENTER,
        APPLY,
        FINISH
    } cal_state_e;

endpackage

// File: rtl/adc_eye_tracker.sv
// ---------------------------------------------------------------------------
// adc_eye_tracker
// Tracks the current run of consecutive good taps and keeps the longest run
// seen so far during a sweep.
// Ports:
//   clk10m, rst_IODELAY - clock and asynchronous active-high reset
//   clear      - wipe current and best runs (start of a sweep)
//   step       - one tap has been evaluated; 'good' holds its verdict
//   good       - the evaluated tap passed
//   last       - the evaluated tap is the final one; close any open run
//   tap        - tap number being evaluated
//   best_start - first tap of the longest run
//   best_len   - length of the longest run
// ---------------------------------------------------------------------------
module adc_eye_tracker
    import adc_cal_pkg::*;
(
    input  logic             clk10m,
    input  logic             rst_IODELAY,
    input  logic             clear,
    input  logic             step,
    input  logic             good,
    input  logic             last,
    input  logic [TAP_W-1:0] tap,
    output logic [TAP_W-1:0] best_start,
    output logic [LEN_W-1:0] best_len
);

    logic [TAP_W-1:0] cur_start_q, cur_start_d;
    logic [LEN_W-1:0] cur_len_q,   cur_len_d;
    logic [TAP_W-1:0] best_start_q, best_start_d;
    logic [LEN_W-1:0] best_len_q,   best_len_d;

    logic [TAP_W-1:0] cand_start;
    logic [LEN_W-1:0] cand_len;

    always_ff @(posedge clk10m or posedge rst_IODELAY) begin
        if (rst_IODELAY) begin
            cur_start_q  <= '0;
            cur_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
        end else begin
            cur_start_q  <= cur_start_d;
            cur_len_q    <= cur_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
        end
    end

    always_comb begin
        cur_start_d  = cur_start_q;
        cur_len_d    = cur_len_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;

        // The run as it would stand after including this tap; on the last
        // tap a good verdict must be folded in before the run is closed.
        cand_len   = good ? (cur_len_q + 1'b1) : cur_len_q;
        cand_start = (good && (cur_len_q == '0)) ? tap : cur_start_q;

        if (clear) begin
            cur_start_d  = '0;
            cur_len_d    = '0;
            best_start_d = '0;
            best_len_d   = '0;
        end else if (step) begin
            if (!good || last) begin
                // Strictly longer only, so an equal later run never
                // displaces an earlier one.
                if (cand_len > best_len_q) begin
                    best_start_d = cand_start;
                    best_len_d   = cand_len;
                end
                cur_start_d = '0;
                cur_len_d   = '0;
            end else begin
                cur_start_d = cand_start;
                cur_len_d   = cand_len;
            end
        end
    end

    assign best_start = best_start_q;
    assign best_len   = best_len_q;

endmodule

// File: rtl/adc_idelay_tap_cal.sv
// ---------------------------------------------------------------------------
// adc_idelay_tap_cal
// Sweeps all 512 IDELAY taps, samples a synchronized test-pattern match flag
// at each tap, finds the longest run of good taps and loads its centre.
// Optional build macro:
//   ADC_CAL_READBACK_EN - when defined, each loaded tap is verified against
//                         a_CNTVALUEOUT; a mismatch aborts with cal_fail.
//                         When undefined, a_CNTVALUEOUT is ignored.
// Ports:
//   clk10m, rst_IODELAY - clock and asynchronous active-high reset
//   start         - one-cycle sweep request (ignored while busy)
//   pattern_ok    - asynchronous pattern match flag from the data domain
//   a_CNTVALUEOUT - registered IDELAY tap readback
//   load          - IDELAY load strobe (two cycles wide)
//   a_CNTVALUEIN  - tap value presented to the IDELAY
//   busy, done, cal_fail - status (done is a level held until next start)
//   eye_start, eye_width, tap_sel - calibration results
// ---------------------------------------------------------------------------
module adc_idelay_tap_cal
    import adc_cal_pkg::*;
#(
    parameter int SETTLE_CYC  = 16,
    parameter int SAMPLE_CYC  = 32,
    parameter int MIN_EYE     = 8,
    parameter int DEFAULT_TAP = 0
)(
    input  logic             clk10m,
    input  logic             rst_IODELAY,
    input  logic             start,
    input  logic             pattern_ok,
    input  logic [TAP_W-1:0] a_CNTVALUEOUT,
    output logic             load,
    output logic [TAP_W-1:0] a_CNTVALUEIN,
    output logic             busy,
    output logic             done,
    output logic             cal_fail,
    output logic [TAP_W-1:0] eye_start,
    output logic [LEN_W-1:0] eye_width,
    output logic [TAP_W-1:0] tap_sel
);

    cal_state_e       state_q, state_d;
    logic [TAP_W-1:0] tap_q, tap_d;
    logic [TAP_W-1:0] cntin_q, cntin_d;
    logic             load_q, load_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cal_fail_q, cal_fail_d;
    logic [TAP_W-1:0] eye_start_q, eye_start_d;
    logic [LEN_W-1:0] eye_width_q, eye_width_d;
    logic [TAP_W-1:0] tap_sel_q, tap_sel_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             good_q, good_d;
    logic             ok_meta_q, ok_meta_d;
    logic             ok_sync_q, ok_sync_d;

    logic             trk_clear;
    logic             trk_step;
    logic             trk_last;
    logic [TAP_W-1:0] best_start;
    logic [LEN_W-1:0] best_len;
    logic [LEN_W-1:0] center_sum;
    logic [TAP_W-1:0] center_tap;

`ifndef ADC_CAL_READBACK_EN
    logic unused_readback;
    assign unused_readback = ^a_CNTVALUEOUT;
`endif

    adc_eye_tracker u_tracker (
        .clk10m      (clk10m),
        .rst_IODELAY (rst_IODELAY),
        .clear       (trk_clear),
        .step        (trk_step),
        .good        (good_q),
        .last        (trk_last),
        .tap         (tap_q),
        .best_start  (best_start),
        .best_len    (best_len)
    );

    always_ff @(posedge clk10m or posedge rst_IODELAY) begin
        if (rst_IODELAY) begin
            state_q     <= IDLE;
            tap_q       <= '0;
            cntin_q     <= '0;
            load_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cal_fail_q  <= 1'b0;
            eye_start_q <= '0;
            eye_width_q <= '0;
            tap_sel_q   <= '0;
            wait_cnt_q  <= '0;
            good_q      <= 1'b0;
            ok_meta_q   <= 1'b0;
            ok_sync_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            cntin_q     <= cntin_d;
            load_q      <= load_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cal_fail_q  <= cal_fail_d;
            eye_start_q <= eye_start_d;
            eye_width_q <= eye_width_d;
            tap_sel_q   <= tap_sel_d;
            wait_cnt_q  <= wait_cnt_d;
            good_q      <= good_d;
            ok_meta_q   <= ok_meta_d;
            ok_sync_q   <= ok_sync_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        cntin_d     = cntin_q;
        load_d      = 1'b0;
        busy_d      = busy_q;
        done_d      = done_q;
        cal_fail_d  = cal_fail_q;
        eye_start_d = eye_start_q;
        eye_width_d = eye_width_q;
        tap_sel_d   = tap_sel_q;
        wait_cnt_d  = wait_cnt_q;
        good_d      = good_q;
        ok_meta_d   = pattern_ok;
        ok_sync_d   = ok_meta_q;
        trk_clear   = 1'b0;
        trk_step    = 1'b0;
        trk_last    = 1'b0;

        // start + len <= 512 keeps the centre below 512; the carry bit is
        // only a guard so the result can never wrap.
        center_sum = {1'b0, best_start} + (best_len >> 1);
        center_tap = center_sum[TAP_W] ? MAX_TAP : center_sum[TAP_W-1:0];

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LOAD;
                    tap_d      = '0;
                    cntin_d    = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    cal_fail_d = 1'b0;
                    wait_cnt_d = '0;
                    trk_clear  = 1'b1;
                end
            end

            // Count 0 is the setup cycle with a_CNTVALUEIN already stable,
            // counts 1 and 2 have the registered strobe high, and the value
            // is still held in the cycle after the strobe drops.
            LOAD, APPLY: begin
                if (wait_cnt_q < CNT_W'(2)) begin
                    load_d     = 1'b1;
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end else begin
                    wait_cnt_d = '0;
                    state_d    = (state_q == LOAD) ? SETTLE : FINISH;
                end
            end

            SETTLE: begin
                if (wait_cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    wait_cnt_d = '0;
                    state_d    = CHECK;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            CHECK: begin
`ifdef ADC_CAL_READBACK_EN
                if (a_CNTVALUEOUT != cntin_q) begin
                    cal_fail_d = 1'b1;
                    state_d    = FINISH;
                end else begin
                    good_d     = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = SAMPLE;
                end
`else
                good_d     = 1'b1;
                wait_cnt_d = '0;
                state_d    = SAMPLE;
`endif
            end

            SAMPLE: begin
                good_d = good_q & ok_sync_q;
                if (wait_cnt_q == CNT_W'(SAMPLE_CYC - 1)) begin
                    wait_cnt_d = '0;
                    state_d    = NEXT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            NEXT: begin
                trk_step = 1'b1;
                trk_last = (tap_q == MAX_TAP);
                if (tap_q == MAX_TAP) begin
                    state_d = CENTER;
                end else begin
                    tap_d      = tap_q + 1'b1;
                    cntin_d    = tap_q + 1'b1;
                    wait_cnt_d = '0;
                    state_d    = LOAD;
                end
            end

            CENTER: begin
                if (best_len >= LEN_W'(MIN_EYE)) begin
                    tap_sel_d = center_tap;
                    cntin_d   = center_tap;
                end else begin
                    tap_sel_d  = TAP_W'(DEFAULT_TAP);
                    cntin_d    = TAP_W'(DEFAULT_TAP);
                    cal_fail_d = 1'b1;
                end
                wait_cnt_d = '0;
                state_d    = APPLY;
            end

            FINISH: begin
                eye_start_d = best_start;
                eye_width_d = best_len;
                busy_d      = 1'b0;
                done_d      = 1'b1;
                state_d     = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign load         = load_q;
    assign a_CNTVALUEIN = cntin_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign cal_fail     = cal_fail_q;
    assign eye_start    = eye_start_q;
    assign eye_width    = eye_width_q;
    assign tap_sel      = tap_sel_q;

endmodule

// File: tb/tb_adc_idelay_tap_cal.sv
// ---------------------------------------------------------------------------
// tb_adc_idelay_tap_cal
// Drives the tap calibrator with an IDELAY/ADC environment whose good-tap map
// is set per test, and compares the outcome against a reference that picks
// the longest run of good taps straight from the map.
// ---------------------------------------------------------------------------
module tb_adc_idelay_tap_cal;

    localparam int SETTLE_TB   = 3;
    localparam int SAMPLE_TB   = 3;
    localparam int MIN_EYE_TB  = 8;
    localparam int DEF_TAP_TB  = 0;
    localparam int NUM_TAPS    = 512;
    localparam int SWEEP_LOADS = NUM_TAPS + 1;

    logic       clk10m = 1'b0;
    logic       rst_IODELAY;
    logic       start;
    logic       pattern_ok;
    logic [8:0] a_CNTVALUEOUT;
    logic       load;
    logic [8:0] a_CNTVALUEIN;
    logic       busy;
    logic       done;
    logic       cal_fail;
    logic [8:0] eye_start;
    logic [9:0] eye_width;
    logic [8:0] tap_sel;

    int vectors     = 0;
    int miscompares = 0;

    // Environment state: good-tap map, optional one-cycle dropout tap,
    // readback fault, and strobe bookkeeping.
    bit         goodMask [NUM_TAPS];
    int         glitchTap     = -1;
    bit         stuckReadback = 1'b0;
    int         loadPulses    = 0;
    int         strobeErrors  = 0;
    int         sinceLoad     = 0;
    int         pulseLen      = 0;
    logic       prevLoad      = 1'b0;
    logic [8:0] prevCntin     = '0;
    logic [8:0] pulseVal      = '0;

    adc_idelay_tap_cal #(
        .SETTLE_CYC  (SETTLE_TB),
        .SAMPLE_CYC  (SAMPLE_TB),
        .MIN_EYE     (MIN_EYE_TB),
        .DEFAULT_TAP (DEF_TAP_TB)
    ) dut (
        .clk10m        (clk10m),
        .rst_IODELAY   (rst_IODELAY),
        .start         (start),
        .pattern_ok    (pattern_ok),
        .a_CNTVALUEOUT (a_CNTVALUEOUT),
        .load          (load),
        .a_CNTVALUEIN  (a_CNTVALUEIN),
        .busy          (busy),
        .done          (done),
        .cal_fail      (cal_fail),
        .eye_start     (eye_start),
        .eye_width     (eye_width),
        .tap_sel       (tap_sel)
    );

    always #50 clk10m = ~clk10m;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus();
        @(negedge clk10m);
        start = 1'b1;
        @(negedge clk10m);
        start = 1'b0;
    endtask

    function automatic bit isGood(input int t);
        return goodMask[t] && (t != glitchTap);
    endfunction

    // Longest stretch of consecutive good taps, earliest one on a tie.
    task automatic modelEye(output int bStart, output int bLen);
        bStart = 0;
        bLen   = 0;
        for (int s = 0; s < NUM_TAPS; s++) begin
            int len;
            len = 0;
            while ((s + len) < NUM_TAPS && isGood(s + len)) len++;
            if (len > bLen) begin
                bLen   = len;
                bStart = s;
            end
        end
    endtask

    task automatic clearMask();
        for (int t = 0; t < NUM_TAPS; t++) goodMask[t] = 1'b0;
        glitchTap = -1;
    endtask

    task automatic setRange(input int lo, input int hi);
        for (int t = lo; t <= hi && t < NUM_TAPS; t++) goodMask[t] = 1'b1;
    endtask

    task automatic randomMask();
        int nWin;
        clearMask();
        nWin = $urandom_range(1, 3);
        for (int w = 0; w < nWin; w++) begin
            int lo;
            lo = $urandom_range(0, NUM_TAPS - 1);
            setRange(lo, lo + $urandom_range(1, 80) - 1);
        end
        if ($urandom_range(0, 1) == 1) glitchTap = $urandom_range(0, NUM_TAPS - 1);
    endtask

    task automatic waitDone();
        int cyc;
        cyc = 0;
        while (done !== 1'b1 && cyc < 8000) begin
            @(negedge clk10m);
            cyc++;
        end
    endtask

    task automatic runSweep(input string tag, input bit poke);
        int bStart, bLen, expSel, p0, e0;
        bit expFail;
        modelEye(bStart, bLen);
        expFail = (bLen < MIN_EYE_TB);
        expSel  = expFail ? DEF_TAP_TB : bStart + bLen / 2;
        p0 = loadPulses;
        e0 = strobeErrors;
        applyStimulus();
        checkOutput({tag, ".busyAtStart"}, busy, 1);
        checkOutput({tag, ".firstTap"}, a_CNTVALUEIN, 0);
        if (poke) begin
            repeat (500) @(negedge clk10m);
            applyStimulus();
        end
        waitDone();
        checkOutput({tag, ".done"}, done, 1);
        checkOutput({tag, ".calFail"}, cal_fail, expFail);
        checkOutput({tag, ".eyeStart"}, eye_start, bStart);
        checkOutput({tag, ".eyeWidth"}, eye_width, bLen);
        checkOutput({tag, ".tapSel"}, tap_sel, expSel);
        checkOutput({tag, ".appliedTap"}, a_CNTVALUEIN, expSel);
        checkOutput({tag, ".loadPulses"}, loadPulses - p0, SWEEP_LOADS);
        checkOutput({tag, ".strobeShape"}, strobeErrors - e0, 0);
        repeat (3) @(negedge clk10m);
        checkOutput({tag, ".doneHeld"}, done, 1);
        checkOutput({tag, ".busyLow"}, busy, 0);
    endtask

    // IDELAY/ADC environment: watches the load strobe, models readback and
    // produces pattern_ok from the tap currently presented.
    initial begin
        pattern_ok    = 1'b0;
        a_CNTVALUEOUT = '0;
        forever begin
            @(negedge clk10m);
            if (rst_IODELAY) begin
                prevLoad  = 1'b0;
                pulseLen  = 0;
                sinceLoad = 0;
            end else begin
                if (load) begin
                    if (!prevLoad) begin
                        loadPulses++;
                        pulseLen = 1;
                        pulseVal = a_CNTVALUEIN;
                        if (a_CNTVALUEIN !== prevCntin) strobeErrors++;
                    end else begin
                        pulseLen++;
                        if (a_CNTVALUEIN !== pulseVal) strobeErrors++;
                    end
                    sinceLoad     = 0;
                    a_CNTVALUEOUT = stuckReadback ? 9'd0 : a_CNTVALUEIN;
                end else begin
                    if (prevLoad && (pulseLen != 2 || a_CNTVALUEIN !== pulseVal)) strobeErrors++;
                    sinceLoad++;
                end
                prevLoad = load;
            end
            prevCntin  = a_CNTVALUEIN;
            pattern_ok = goodMask[a_CNTVALUEIN] &&
                         !((int'(a_CNTVALUEIN) == glitchTap) && (sinceLoad == 4));
        end
    end

    initial begin
        int p0, cyc;
        rst_IODELAY = 1'b1;
        start       = 1'b0;
        clearMask();
        repeat (3) @(negedge clk10m);
        checkOutput("reset.load", load, 0);
        checkOutput("reset.cntIn", a_CNTVALUEIN, 0);
        checkOutput("reset.busy", busy, 0);
        checkOutput("reset.done", done, 0);
        checkOutput("reset.calFail", cal_fail, 0);
        checkOutput("reset.eyeStart", eye_start, 0);
        checkOutput("reset.eyeWidth", eye_width, 0);
        checkOutput("reset.tapSel", tap_sel, 0);
        rst_IODELAY = 1'b0;
        repeat (2) @(negedge clk10m);

        clearMask(); setRange(100, 199);
        runSweep("t1.window100", 1'b1);

        clearMask(); setRange(10, 29); setRange(300, 359);
        runSweep("t2.twoWindows", 1'b0);

        clearMask(); setRange(480, 511);
        runSweep("t3.topEdge", 1'b0);

        clearMask();
        runSweep("t3.noEye", 1'b0);

        clearMask(); setRange(100, 199); glitchTap = 150;
        runSweep("t4.dropout", 1'b0);

        clearMask(); setRange(100, 199);
        stuckReadback = 1'b1;
`ifdef ADC_CAL_READBACK_EN
        p0 = loadPulses;
        applyStimulus();
        waitDone();
        checkOutput("t5.done", done, 1);
        checkOutput("t5.calFail", cal_fail, 1);
        checkOutput("t5.loadPulses", loadPulses - p0, 2);
        checkOutput("t5.eyeWidth", eye_width, 0);
        checkOutput("t5.busy", busy, 0);
`else
        runSweep("t5.readbackIgnored", 1'b0);
`endif
        stuckReadback = 1'b0;

        clearMask(); setRange(50, 260);
        applyStimulus();
        cyc = 0;
        while (!(load === 1'b1 && a_CNTVALUEIN === 9'd200) && cyc < 4000) begin
            @(negedge clk10m);
            cyc++;
        end
        checkOutput("t6.reachedTap200", a_CNTVALUEIN, 200);
        #10 rst_IODELAY = 1'b1;
        #1;
        checkOutput("t6.loadAtReset", load, 0);
        checkOutput("t6.busyAtReset", busy, 0);
        checkOutput("t6.cntInAtReset", a_CNTVALUEIN, 0);
        checkOutput("t6.doneAtReset", done, 0);
        repeat (2) @(negedge clk10m);
        rst_IODELAY = 1'b0;
        p0 = loadPulses;
        repeat (30) @(negedge clk10m);
        checkOutput("t6.noLoadAfterReset", loadPulses - p0, 0);
        checkOutput("t6.idleAfterReset", busy, 0);
        runSweep("t6.resweep", 1'b0);

        for (int r = 0; r < 2; r++) begin
            randomMask();
            runSweep($sformatf("rand%0d", r), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
